// File: rtl/ms_dbg_host_u.sv
// Debug-link UART initiator: sends one header+payload frame per command and
// collects read bytes or the write acknowledge from the target bridge.
module ms_dbg_host_u #(
  parameter logic [15:0] CBaudDiv = 16'd7,
  parameter logic [23:0] CTimeout = 24'hFFFFFF,
  parameter logic [7:0]  CAckByte = 8'h5A
) (
  input  logic        AClkH,
  input  logic        AResetHN,
  input  logic        AClkHEn,
  input  logic        ACmdReq,
  output logic        ACmdAck,
  input  logic        ACmdWr,
  input  logic [11:0] ACmdAddr,
  input  logic [15:0] ACmdLen,
  input  logic [7:0]  AWrData,
  input  logic        AWrValid,
  output logic        AWrReady,
  output logic [7:0]  ARdData,
  output logic        ARdValid,
  output logic        ABusy,
  output logic        ADone,
  output logic        AErr,
  output logic        ADbgTx,
  input  logic        ADbgRx
);

  localparam logic [15:0] RX_HALF = (CBaudDiv + 16'd1) >> 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WR, S_RD, S_WAIT, S_DONE, S_ERR} state_t;

  state_t      state, state_nx;
  logic        wr_q;
  logic [11:0] addr_q;
  logic [15:0] rem;
  logic [2:0]  hdr_idx;
  logic [9:0]  tx_sh;
  logic [3:0]  tx_bits;
  logic [15:0] tx_cnt;
  logic        rx_s1, rx_s2, rx_prev, rx_active;
  logic [3:0]  rx_idx;
  logic [15:0] rx_cnt;
  logic [7:0]  rx_sh;
  logic [7:0]  rd_data;
  logic [23:0] tmo;

  logic       tx_free, rx_got, in_wait;
  logic       tx_load, acc, wr_take, rd_take;
  logic [7:0] tx_byte, hdr_byte;

  // The shifter is free during the last cycle of a stop bit so frames stay back-to-back.
  assign tx_free = (tx_bits == 4'd0) || (tx_bits == 4'd1 && tx_cnt == 16'd0);
  assign rx_got  = rx_active && rx_idx == 4'd9 && rx_cnt == 16'd0 && rx_s2;
  assign in_wait = (state == S_RD) || (state == S_WAIT);

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      3'd0:    hdr_byte = {wr_q, 3'b000, addr_q[11:8]};
      3'd1:    hdr_byte = addr_q[7:0];
      3'd2:    hdr_byte = rem[15:8];
      default: hdr_byte = rem[7:0];
    endcase
  end

  always_comb begin
    state_nx = state;
    tx_load  = 1'b0;
    tx_byte  = 8'h00;
    acc      = 1'b0;
    wr_take  = 1'b0;
    rd_take  = 1'b0;
    if (AClkHEn) begin
      case (state)
        S_IDLE: if (ACmdReq) begin
          acc      = 1'b1;
          state_nx = S_HDR;
        end
        S_HDR: begin
          if (hdr_idx != 3'd4) begin
            if (tx_free) begin
              tx_load = 1'b1;
              tx_byte = hdr_byte;
              if (hdr_idx == 3'd3 && wr_q && rem != 16'd0) state_nx = S_WR;
            end
          end else if (tx_bits == 4'd0) begin
            if (wr_q)                state_nx = S_WAIT;
            else if (rem != 16'd0)   state_nx = S_RD;
            else                     state_nx = S_DONE;
          end
        end
        S_WR: begin
          if (rem != 16'd0) begin
            if (tx_free && AWrValid) begin
              tx_load = 1'b1;
              tx_byte = AWrData;
              wr_take = 1'b1;
            end
          end else if (tx_bits == 4'd0) begin
            state_nx = S_WAIT;
          end
        end
        S_RD: begin
          if (rx_got) begin
            rd_take = 1'b1;
            if (rem == 16'd1) state_nx = S_DONE;
          end else if (tmo == 24'd1) begin
            state_nx = S_ERR;
          end
        end
        S_WAIT: begin
          if (rx_got)              state_nx = (rx_sh == CAckByte) ? S_DONE : S_ERR;
          else if (tmo == 24'd1)   state_nx = S_ERR;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state     <= S_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= 12'h000;
      rem       <= 16'd0;
      hdr_idx   <= 3'd0;
      tx_sh     <= 10'h3FF;
      tx_bits   <= 4'd0;
      tx_cnt    <= 16'd0;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_active <= 1'b0;
      rx_idx    <= 4'd0;
      rx_cnt    <= 16'd0;
      rx_sh     <= 8'h00;
      rd_data   <= 8'h00;
      tmo       <= 24'd0;
    end else if (AClkHEn) begin
      state <= state_nx;
      if (acc) begin
        wr_q    <= ACmdWr;
        addr_q  <= ACmdAddr;
        rem     <= ACmdLen;
        hdr_idx <= 3'd0;
      end
      if (state == S_HDR && tx_load) hdr_idx <= hdr_idx + 3'd1;
      if (wr_take || rd_take) rem <= rem - 16'd1;
      if (rd_take) rd_data <= rx_sh;

      if (tx_load) begin
        tx_sh   <= {1'b1, tx_byte, 1'b0};
        tx_bits <= 4'd10;
        tx_cnt  <= CBaudDiv;
      end else if (tx_bits != 4'd0) begin
        if (tx_cnt == 16'd0) begin
          tx_sh   <= {1'b1, tx_sh[9:1]};
          tx_bits <= tx_bits - 4'd1;
          tx_cnt  <= CBaudDiv;
        end else begin
          tx_cnt <= tx_cnt - 16'd1;
        end
      end

      rx_s1   <= ADbgRx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (!rx_active) begin
        if (rx_prev && !rx_s2) begin
          rx_active <= 1'b1;
          rx_idx    <= 4'd0;
          rx_cnt    <= RX_HALF;
        end
      end else if (rx_cnt != 16'd0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= CBaudDiv;
        rx_idx <= rx_idx + 4'd1;
        // idx 0 re-checks the start bit; idx 9 is the stop bit (bad stop just drops the byte)
        if (rx_idx == 4'd0) begin
          if (rx_s2) rx_active <= 1'b0;
        end else if (rx_idx == 4'd9) begin
          rx_active <= 1'b0;
        end else begin
          rx_sh <= {rx_s2, rx_sh[7:1]};
        end
      end

      if (!in_wait || rx_got)  tmo <= CTimeout - 24'd1;
      else if (tmo != 24'd0)   tmo <= tmo - 24'd1;
    end
  end

  assign ACmdAck  = acc;
  assign AWrReady = wr_take;
  assign ARdValid = rd_take;
  assign ARdData  = rd_take ? rx_sh : rd_data;
  assign ABusy    = (state != S_IDLE);
  assign ADone    = AClkHEn && (state == S_DONE);
  assign AErr     = AClkHEn && (state == S_ERR);
  assign ADbgTx   = tx_sh[0];

endmodule

// File: doc/ms_dbg_host_u.md
Name: ms_dbg_host_u

Overview:
UART-side initiator for the debug link, the opposite end of the target's debug UART bridge.
- Accepts a single debug-bus transaction (group/register address, byte length, direction) from a local master.
- Serialises it as a link frame on ADbgTx and streams write data out.
- Collects read data or the write acknowledge from ADbgRx.
- Used in board-to-board debug and as the stimulus driver for target-side debug regression.

Parameters:
CBaudDiv, 16'd7, bit period = CBaudDiv+1 enabled clocks (AClkHEn=1)
CTimeout, 24'hFFFFFF, max enabled clocks between received bytes before error
CAckByte, 8'h5A, byte the target returns on completion of a write frame

Ports:
AClkH  in  1  clock
AResetHN  in  1  asynchronous active-low reset
AClkHEn  in  1  clock enable; all state advances only when 1
ACmdReq  in  1  transaction request, level, sampled in Idle
ACmdAck  out  1  one-cycle pulse: command accepted, fields latched
ACmdWr  in  1  1=write, 0=read
ACmdAddr  in  12  debug-bus address ([11:8] group, [7:0] register)
ACmdLen  in  16  payload byte count
AWrData  in  8  write payload byte
AWrValid  in  1  write byte valid
AWrReady  out  1  one-cycle pulse: AWrData consumed
ARdData  out  8  received read byte
ARdValid  out  1  one-cycle pulse: ARdData valid
ABusy  out  1  transaction in progress
ADone  out  1  one-cycle pulse: transaction completed OK
AErr  out  1  one-cycle pulse: timeout or bad ack
ADbgTx  out  1  UART TX, idle high
ADbgRx  in  1  UART RX, asynchronous

Behaviour:
- Reset values: ADbgTx=1, ARdData=0; all other outputs 0. Reset mid-frame aborts immediately; TX returns high with no partial stop bit.
- UART format: 8N1, LSB first. TX shifts on the baud tick. RX passes through a 2-flop synchroniser, detects the start edge, and samples at mid-bit ((CBaudDiv+1)/2 after the edge). A start bit that is not still low at mid-bit is ignored. A framing error (stop bit = 0) drops the byte.
- Frame out: H0={ACmdWr,3'b000,Addr[11:8]}, H1=Addr[7:0], H2=Len[15:8], H3=Len[7:0], then Len payload bytes (write only). Bytes are back-to-back with no idle bit between them.
- FSM states: Idle, Hdr, WrData, RdData, WaitAck, Done, Err.
- Idle: when ACmdReq=1, latch the command fields, pulse ACmdAck, set ABusy=1, go to Hdr.
- Hdr: send H0..H3.
  - Write with Len>0: go to WrData.
  - Write with Len=0: go to WaitAck.
  - Read with Len>0: go to RdData.
  - Read with Len=0: go to Done.
- WrData: when the TX shifter is empty and AWrValid=1, pulse AWrReady, load the byte, decrement the remaining count. TX stays high while AWrValid=0 (the target tolerates gaps). After the last byte's stop bit, go to WaitAck.
- RdData: each received byte pulses ARdValid with ARdData in the same cycle and decrements the count. At 0, go to Done.
- WaitAck: received byte == CAckByte goes to Done; any other byte goes to Err.
- The timeout counter runs in RdData and WaitAck, reloads on each received byte, and goes to Err when CTimeout elapses.
- Done and Err each last one cycle: pulse ADone or AErr, clear ABusy, return to Idle. A new ACmdReq is accepted no earlier than the next cycle.
- RX bytes arriving in Idle, Hdr or WrData are discarded.
- Remaining count is 16-bit. Len=16'hFFFF is legal; there is no wrap.
- AClkHEn=0 freezes every counter and state; the pulse outputs are driven only on enabled cycles.

Test Plan:
- Read: Addr=12'h103, Len=2, CBaudDiv=7. TX must carry 01,03,00,02 with 8 clocks per bit. Target sends 11,22 -> ARdValid twice with 11 then 22, then ADone.
- Write: Addr=12'h004, Len=3, data AA,BB,CC. TX carries 80,04,00,03,AA,BB,CC; AWrReady pulses 3 times. Target returns 5A -> ADone.
- Write ack wrong: target returns 00 -> AErr, no ADone, ABusy falls.
- Read timeout: CTimeout=100, target sends 1 of 4 bytes -> AErr 100 enabled clocks after that byte.
- Len=0 read: only 4 header bytes sent, ADone follows H3's stop bit. Len=0 write: waits for 5A.
- AWrValid stalled 50 cycles mid-payload: TX stays 1 and the frame resumes intact. Reset asserted mid-H2: ADbgTx=1 and ABusy=0 immediately.
